// File: rtl/tdm_demux_1x8.sv
// Receive end of a serial 8-slot TDM link. Each accepted bit is steered into a
// shadow lane, and every completed frame is presented as a parallel word.
module tdm_demux_1x8 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sync,
    output logic [7:0] out,
    output logic       out_valid,
    output logic [2:0] slot,
    output logic       sync_err
);

    logic [7:0] shadow;
    logic [7:0] shadow_next;
    logic [2:0] eff_slot;
    logic [2:0] lane;
    logic [2:0] slot_next;
    logic       complete;
    logic       sync_err_next;

    // sync overrides the counter before lane selection, so a sync-forced bit
    // always lands in slot 0 and can never complete a frame.
    always_comb begin
        eff_slot      = sync ? 3'd0 : slot;
        lane          = LSB_FIRST ? eff_slot : ~eff_slot;
        shadow_next   = shadow;
        slot_next     = slot;
        complete      = 1'b0;
        sync_err_next = sync && (slot != 3'd0);
        if (din_valid) begin
            shadow_next[lane] = din;
            slot_next         = eff_slot + 3'd1;
            complete          = (eff_slot == 3'd7);
        end else if (sync) begin
            slot_next = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            slot      <= '0;
            sync_err  <= 1'b0;
        end else begin
            shadow    <= shadow_next;
            slot      <= slot_next;
            out_valid <= complete;
            sync_err  <= sync_err_next;
            if (complete) begin
                out <= shadow_next;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Scoreboard bench for tdm_demux_1x8: one LSB-first and one MSB-first instance
// share the serial stream; a monitor pops expected words on each out_valid.
module tb_tdm_demux_1x8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       sync;
    logic [7:0] out1, out0;
    logic       out_valid1, out_valid0;
    logic [2:0] slot1, slot0;
    logic       sync_err1, sync_err0;

    logic [7:0] q1[$];
    logic [7:0] q0[$];
    int n_pass = 0;
    int n_checks = 0;
    int serr_seen = 0;
    int serr_exp = 0;
    int cyc = 0;
    int last_v = 0;
    int prev_v = 0;

    tdm_demux_1x8 #(.LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
        .out(out1), .out_valid(out_valid1), .slot(slot1), .sync_err(sync_err1)
    );

    tdm_demux_1x8 #(.LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
        .out(out0), .out_valid(out_valid0), .slot(slot0), .sync_err(sync_err0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every out_valid strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (out_valid1 === 1'b1) begin
            if (q1.size() == 0) chk("unexpected out_valid lsb", 8'd1, 8'd0);
            else chk("out lsb_first", out1, q1.pop_front());
            prev_v = last_v;
            last_v = cyc;
        end
        if (out_valid0 === 1'b1) begin
            if (q0.size() == 0) chk("unexpected out_valid msb", 8'd1, 8'd0);
            else chk("out msb_first", out0, q0.pop_front());
        end
        if (sync_err1 === 1'b1) serr_seen++;
    end

    task automatic step(input logic d, input logic v, input logic s);
        din = d; din_valid = v; sync = s;
        @(posedge clk);
        #1;
        din = 1'b0; din_valid = 1'b0; sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    // w: word as seen LSB-first (serial bit k = w[k]); w0: hand-computed MSB-first result.
    task automatic send_word(input logic [7:0] w, input logic [7:0] w0,
                             input logic s, input logic gaps);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                q1.push_back(w);
                q0.push_back(w0);
            end
            step(w[k], 1'b1, s && (k == 0));
            if (gaps && (k == 1 || k == 4)) begin
                repeat (3) begin
                    step(1'b0, 1'b0, 1'b0);
                    chk("gap slot hold", {5'b0, slot1}, 8'(k + 1));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sync = 1'b0;
        // Reset held with random activity on the inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            din = 1'($urandom); din_valid = 1'($urandom); sync = 1'($urandom);
            #1;
            chk("reset out", out1, 8'h00);
            chk("reset out_valid", {7'b0, out_valid1}, 8'h00);
            chk("reset slot", {5'b0, slot1}, 8'h00);
            chk("reset sync_err", {7'b0, sync_err1}, 8'h00);
            chk("reset out msb", out0, 8'h00);
        end
        @(posedge clk);
        #1;
        din = 1'b0; din_valid = 1'b0; sync = 1'b0;
        rst_n = 1'b1;
        chk("post-reset slot", {5'b0, slot1}, 8'h00);

        // Loopback: serial 1,1,0,1,0,1,1,0.
        send_word(8'h6B, 8'hD6, 1'b0, 1'b0);
        idle(2);
        chk("out hold", out1, 8'h6B);
        chk("slot after frame", {5'b0, slot1}, 8'h00);

        // Gapped input.
        send_word(8'h6B, 8'hD6, 1'b0, 1'b1);
        idle(2);

        // Back-to-back frames with sync at slot 0 (silent).
        send_word(8'hA5, 8'hA5, 1'b1, 1'b0);
        send_word(8'h3C, 8'h3C, 1'b1, 1'b0);
        idle(2);
        chk("back-to-back spacing", 8'(last_v - prev_v), 8'd8);
        chk("no sync_err on aligned sync", 8'(serr_seen), 8'd0);

        // Misalignment: 5 garbage bits, then sync-led frame F0.
        step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        chk("garbage slot", {5'b0, slot1}, 8'd5);
        serr_exp++;
        send_word(8'hF0, 8'h0F, 1'b1, 1'b0);
        idle(2);

        // sync together with a slot-7 bit: sync wins, no completion.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
        chk("slot before sync at 7", {5'b0, slot1}, 8'd7);
        serr_exp++;
        send_word(8'h81, 8'h81, 1'b1, 1'b0);
        idle(2);

        // sync without data resets the counter.
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        serr_exp++;
        step(1'b0, 1'b0, 1'b1);
        chk("slot after bare sync", {5'b0, slot1}, 8'd0);
        send_word(8'h3C, 8'h3C, 1'b0, 1'b0);
        idle(2);

        // MSB-first instance sees serial 0,1,1,0,1,0,1,1 -> 6B.
        send_word(8'hD6, 8'h6B, 1'b0, 1'b0);
        idle(2);
        chk("msb_first out hold", out0, 8'h6B);

        // Reset mid-frame.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midframe reset out", out1, 8'h00);
        chk("midframe reset out msb", out0, 8'h00);
        chk("midframe reset slot", {5'b0, slot1}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("first bit after reset slot", {5'b0, slot1}, 8'd1);
        idle(2);

        chk("scoreboard drained lsb", 8'(q1.size()), 8'd0);
        chk("scoreboard drained msb", 8'(q0.size()), 8'd0);
        chk("sync_err pulse count", 8'(serr_seen), 8'(serr_exp));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
